// File: rtl/sauria_pe_pkg.sv
// Shared types and default widths for the PE accumulator.
// Imported by the accumulator top and its saturating adder.
package sauria_pe_pkg;

   localparam int DEF_MUL_W = 32;
   localparam int DEF_ACC_W = 40;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FLUSH,
      DRAIN
   } acc_state_t;

endpackage

// File: rtl/pe_accumulator_sat_adder.sv
// Extends a product to accumulator width and adds it with clamping.
// Reports overflow whenever the result had to be clamped.
module sat_adder
   import sauria_pe_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int MUL_W  = DEF_MUL_W,
   parameter bit SIGNED = 1'b0
) (
   input  logic [ACC_W-1:0] a,
   input  logic [MUL_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

   logic [ACC_W-1:0] b_ext;
   logic [ACC_W:0]   raw;
   logic             a_s;
   logic             b_s;
   logic             r_s;

   always_comb begin
      if (SIGNED) begin
         b_ext = ACC_W'($signed(b));
      end else begin
         b_ext = ACC_W'(b);
      end
   end

   assign raw = {1'b0, a} + {1'b0, b_ext};
   assign a_s = a[ACC_W-1];
   assign b_s = b_ext[ACC_W-1];
   assign r_s = raw[ACC_W-1];

   // signed: overflow only when both operands share a sign the result lost
   always_comb begin
      ovf = 1'b0;
      sum = raw[ACC_W-1:0];
      if (SIGNED) begin
         if ((a_s == b_s) && (r_s != a_s)) begin
            ovf = 1'b1;
            sum = a_s ? S_MIN : S_MAX;
         end
      end else begin
         if (raw[ACC_W]) begin
            ovf = 1'b1;
            sum = U_MAX;
         end
      end
   end

endmodule

// File: rtl/pe_accumulator.sv
// Two-stage product accumulator with per-context length and result drain.
// Products are registered, then folded into a saturating accumulator.
module pe_accumulator
   import sauria_pe_pkg::*;
#(
   parameter int MUL_W  = DEF_MUL_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter bit SIGNED = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en_ff,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_acc_len,
   input  logic [MUL_W-1:0] i_prod,
   input  logic             i_prod_valid,
   output logic             o_prod_ready,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_acc_valid,
   input  logic             i_acc_ready,
   output logic             o_ovf
);

   acc_state_t       state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cnt_q;
   logic             s1_valid;
   logic [MUL_W-1:0] s1_prod;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic             acc_valid_q;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic             accept;
   logic             last_accept;

   sat_adder #(
      .ACC_W  (ACC_W),
      .MUL_W  (MUL_W),
      .SIGNED (SIGNED)
   ) u_add (
      .a   (acc_q),
      .b   (s1_prod),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign o_prod_ready = (state == ACCUM) && (cnt_q < len_q) && i_en_ff;
   assign accept       = i_prod_valid && o_prod_ready;
   assign last_accept  = accept && ((cnt_q + CNT_W'(1)) == len_q);

   assign o_acc       = acc_q;
   assign o_acc_valid = acc_valid_q;
   assign o_ovf       = ovf_q;

   // the drain handshake is the only thing allowed to move during a stall
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         s1_valid    <= 1'b0;
         s1_prod     <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         acc_valid_q <= 1'b0;
      end else if (state == DRAIN) begin
         if (acc_valid_q && i_acc_ready) begin
            state       <= IDLE;
            acc_valid_q <= 1'b0;
         end
      end else if (i_en_ff) begin
         s1_valid <= accept;
         if (accept) begin
            s1_prod <= i_prod;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
         if (s1_valid) begin
            acc_q <= add_sum;
            ovf_q <= ovf_q | add_ovf;
         end
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  len_q <= i_acc_len;
                  cnt_q <= '0;
                  acc_q <= '0;
                  ovf_q <= 1'b0;
                  if (i_acc_len != '0) begin
                     state <= ACCUM;
                  end else begin
                     state       <= DRAIN;
                     acc_valid_q <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (last_accept) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (!s1_valid) begin
                  state       <= DRAIN;
                  acc_valid_q <= 1'b1;
               end
            end
            DRAIN: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: three configurations share one stimulus stream
// and are checked against a saturating arithmetic model.
module tb_pe_accumulator;

   logic        clk;
   logic        rst;
   logic        en;
   logic        start;
   logic [15:0] acc_len;
   logic [31:0] prod;
   logic        pvalid;
   logic        acc_ready;

   logic        u_ready, u_av, u_ovf;
   logic [39:0] u_acc;
   logic        s_ready, s_av, s_ovf;
   logic [39:0] s_acc;
   logic        t_ready, t_av, t_ovf;
   logic [7:0]  t_acc;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] vals[$];
   logic [31:0] acc_q[$];

   pe_accumulator #(.MUL_W(32), .ACC_W(40), .CNT_W(16), .SIGNED(1'b0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_en_ff(en), .i_start(start),
      .i_acc_len(acc_len), .i_prod(prod), .i_prod_valid(pvalid),
      .o_prod_ready(u_ready), .o_acc(u_acc), .o_acc_valid(u_av),
      .i_acc_ready(acc_ready), .o_ovf(u_ovf)
   );

   pe_accumulator #(.MUL_W(32), .ACC_W(40), .CNT_W(16), .SIGNED(1'b1)) s_dut (
      .i_clk(clk), .i_rst(rst), .i_en_ff(en), .i_start(start),
      .i_acc_len(acc_len), .i_prod(prod), .i_prod_valid(pvalid),
      .o_prod_ready(s_ready), .o_acc(s_acc), .o_acc_valid(s_av),
      .i_acc_ready(acc_ready), .o_ovf(s_ovf)
   );

   pe_accumulator #(.MUL_W(8), .ACC_W(8), .CNT_W(16), .SIGNED(1'b0)) t_dut (
      .i_clk(clk), .i_rst(rst), .i_en_ff(en), .i_start(start),
      .i_acc_len(acc_len), .i_prod(prod[7:0]), .i_prod_valid(pvalid),
      .o_prod_ready(t_ready), .o_acc(t_acc), .o_acc_valid(t_av),
      .i_acc_ready(acc_ready), .o_ovf(t_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Saturating sum of the accepted products for one configuration.
   function automatic longint model(input int mw, input int aw,
                                    input bit sg, output bit ov);
      longint a;
      longint p;
      longint mx;
      longint mn;
      a  = 0;
      ov = 1'b0;
      mx = sg ? (64'sd1 <<< (aw - 1)) - 1 : (64'sd1 <<< aw) - 1;
      mn = sg ? -(64'sd1 <<< (aw - 1)) : 0;
      foreach (acc_q[i]) begin
         p = longint'(acc_q[i]) & ((64'sd1 <<< mw) - 1);
         if (sg && p >= (64'sd1 <<< (mw - 1))) p = p - (64'sd1 <<< mw);
         a = a + p;
         if (a > mx) begin a = mx; ov = 1'b1; end
         if (a < mn) begin a = mn; ov = 1'b1; end
      end
      return a;
   endfunction

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; start = 1'b0; acc_len = '0;
      prod = '0; pvalid = 1'b0; acc_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   // Runs one context from start to handshake; returns observations only.
   task automatic drive_ctx(input int len, input int stall_at, input int bp,
                            input bit gaps, input bit poke,
                            output int lat, output bit held,
                            output bit idle, output bit leak);
      int idx;
      int cyc;
      bit stalled;
      logic [39:0] snap;
      idx = 0; cyc = 0; stalled = 0; leak = 0;
      acc_q.delete();
      start = 1'b1; acc_len = 16'(len);
      step();
      start = 1'b0;
      while (idx < vals.size() && cyc < 500) begin
         if (idx == stall_at && !stalled) begin
            stalled = 1; en = 1'b0; pvalid = 1'b1; prod = vals[idx];
            repeat (3) begin
               #1;
               if (u_ready || s_ready || t_ready) leak = 1;
               step();
            end
            en = 1'b1;
         end
         start = poke && (cyc == 1);
         if (poke && cyc == 1) acc_len = 16'd9;
         pvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         prod = pvalid ? vals[idx] : $urandom;
         #1;
         if (pvalid && u_ready) begin
            acc_q.push_back(prod);
            idx++;
         end
         step();
         cyc++;
      end
      start = 1'b0; pvalid = 1'b0;
      lat = 1;
      while (!u_av && lat < 30) begin
         step();
         lat++;
      end
      snap = u_acc; held = 1;
      for (int i = 0; i < bp; i++) begin
         if (!u_av || u_acc !== snap) held = 0;
         step();
      end
      acc_ready = 1'b1;
      #1;
      step();
      acc_ready = 1'b0;
      idle = !u_av && !u_ready;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (u_acc !== 40'd0) begin n_fail++; $display("FAIL rst_acc: got %0d want 0", u_acc); end
      n_tests++;
      if (u_av !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", u_av); end
      n_tests++;
      if (u_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", u_ovf); end
      n_tests++;
      if (u_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", u_ready); end
      n_tests++;
      if (t_acc !== 8'd0) begin n_fail++; $display("FAIL rst_t_acc: got %0d want 0", t_acc); end
   endtask

   task automatic test_unsigned();
      int lat; bit held, idle, leak, ov; longint e;
      vals = '{32'd1, 32'd2, 32'd3, 32'd4};
      drive_ctx(4, -1, 0, 1'b0, 1'b0, lat, held, idle, leak);
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL uns_latency: got %0d want 3", lat); end
      n_tests++;
      if (u_acc !== 40'd10) begin n_fail++; $display("FAIL uns_sum: got %0d want 10", u_acc); end
      n_tests++;
      if (u_ovf !== 1'b0) begin n_fail++; $display("FAIL uns_ovf: got %b want 0", u_ovf); end
      e = model(8, 8, 1'b0, ov);
      n_tests++;
      if (longint'(t_acc) != e) begin n_fail++; $display("FAIL uns_t_sum: got %0d want %0d", t_acc, e); end
      n_tests++;
      if (!idle) begin n_fail++; $display("FAIL uns_idle: got busy want idle"); end
   endtask

   task automatic test_signed();
      int lat; bit held, idle, leak, ov; longint e;
      vals = '{32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFF};
      drive_ctx(3, -1, 0, 1'b0, 1'b0, lat, held, idle, leak);
      n_tests++;
      if (longint'($signed(s_acc)) != -4) begin
         n_fail++; $display("FAIL sgn_sum: got %0d want -4", $signed(s_acc));
      end
      n_tests++;
      if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL sgn_ovf: got %b want 0", s_ovf); end
      e = model(32, 40, 1'b0, ov);
      n_tests++;
      if (longint'(u_acc) != e) begin n_fail++; $display("FAIL sgn_u_sum: got %0d want %0d", u_acc, e); end
      e = model(8, 8, 1'b0, ov);
      n_tests++;
      if (longint'(t_acc) != e || t_ovf !== ov) begin
         n_fail++; $display("FAIL sgn_t_sum: got %0d/%b want %0d/%b", t_acc, t_ovf, e, ov);
      end
   endtask

   task automatic test_saturation();
      int lat; bit held, idle, leak;
      vals = '{32'd200, 32'd100};
      drive_ctx(2, -1, 0, 1'b0, 1'b0, lat, held, idle, leak);
      n_tests++;
      if (t_acc !== 8'd255) begin n_fail++; $display("FAIL sat_sum: got %0d want 255", t_acc); end
      n_tests++;
      if (t_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", t_ovf); end
      n_tests++;
      if (u_acc !== 40'd300 || u_ovf !== 1'b0) begin
         n_fail++; $display("FAIL sat_wide: got %0d/%b want 300/0", u_acc, u_ovf);
      end
   endtask

   task automatic test_stall_backpressure();
      int lat; bit held, idle, leak, ov; longint e;
      vals.delete();
      for (int i = 0; i < 6; i++) vals.push_back(32'($urandom_range(1, 1000)));
      drive_ctx(6, 2, 5, 1'b1, 1'b0, lat, held, idle, leak);
      n_tests++;
      if (leak) begin n_fail++; $display("FAIL stall_ready: got 1 want 0"); end
      n_tests++;
      if (acc_q.size() != 6) begin n_fail++; $display("FAIL stall_count: got %0d want 6", acc_q.size()); end
      e = 0;
      foreach (vals[i]) e = e + longint'(vals[i]);
      n_tests++;
      if (longint'(u_acc) != e) begin n_fail++; $display("FAIL stall_sum: got %0d want %0d", u_acc, e); end
      e = model(8, 8, 1'b0, ov);
      n_tests++;
      if (longint'(t_acc) != e || t_ovf !== ov) begin
         n_fail++; $display("FAIL stall_t_sum: got %0d/%b want %0d/%b", t_acc, t_ovf, e, ov);
      end
      n_tests++;
      if (!held) begin n_fail++; $display("FAIL bp_stable: got changed want held"); end
      n_tests++;
      if (!idle) begin n_fail++; $display("FAIL bp_idle: got busy want idle"); end
   endtask

   task automatic test_len0_ignored_start();
      int lat; bit held, idle, leak, ov; longint e;
      start = 1'b1; acc_len = 16'd0;
      step();
      start = 1'b0;
      n_tests++;
      if (u_av !== 1'b1 || t_av !== 1'b1) begin
         n_fail++; $display("FAIL len0_valid: got %b want 1", u_av);
      end
      n_tests++;
      if (u_acc !== 40'd0 || t_acc !== 8'd0) begin
         n_fail++; $display("FAIL len0_acc: got %0d want 0", u_acc);
      end
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      vals.delete();
      for (int i = 0; i < 3; i++) vals.push_back($urandom);
      drive_ctx(3, -1, 0, 1'b0, 1'b1, lat, held, idle, leak);
      n_tests++;
      if (acc_q.size() != 3 || lat != 3) begin
         n_fail++; $display("FAIL poke_len: got %0d/%0d want 3/3", acc_q.size(), lat);
      end
      e = model(32, 40, 1'b1, ov);
      n_tests++;
      if (longint'($signed(s_acc)) != e) begin
         n_fail++; $display("FAIL poke_sum: got %0d want %0d", $signed(s_acc), e);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit held, idle, leak;
      start = 1'b1; acc_len = 16'd4;
      step();
      start = 1'b0; pvalid = 1'b1; prod = 32'd11;
      step();
      prod = 32'd13;
      step();
      pvalid = 1'b0; rst = 1'b1;
      step();
      n_tests++;
      if (u_acc !== 40'd0 || u_av !== 1'b0 || u_ovf !== 1'b0 || u_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_out: got %0d/%b/%b/%b want 0/0/0/0", u_acc, u_av, u_ovf, u_ready);
      end
      rst = 1'b0;
      vals = '{32'd7};
      drive_ctx(1, -1, 0, 1'b0, 1'b0, lat, held, idle, leak);
      n_tests++;
      if (u_acc !== 40'd7 || s_acc !== 40'd7 || t_acc !== 8'd7) begin
         n_fail++; $display("FAIL rstmid_fresh: got %0d want 7", u_acc);
      end
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL rstmid_lat: got %0d want 3", lat); end
   endtask

   task automatic test_random();
      int lat, len; bit held, idle, leak, ov; longint e;
      for (int k = 0; k < 10; k++) begin
         len = $urandom_range(1, 8);
         vals.delete();
         for (int i = 0; i < len; i++) vals.push_back($urandom);
         drive_ctx(len, -1, $urandom_range(0, 3), 1'b1, 1'b0, lat, held, idle, leak);
         e = model(32, 40, 1'b0, ov);
         n_tests++;
         if (longint'(u_acc) != e || u_ovf !== ov) begin
            n_fail++; $display("FAIL rnd_u: got %0d/%b want %0d/%b", u_acc, u_ovf, e, ov);
         end
         e = model(32, 40, 1'b1, ov);
         n_tests++;
         if (longint'($signed(s_acc)) != e || s_ovf !== ov) begin
            n_fail++; $display("FAIL rnd_s: got %0d/%b want %0d/%b", $signed(s_acc), s_ovf, e, ov);
         end
         e = model(8, 8, 1'b0, ov);
         n_tests++;
         if (longint'(t_acc) != e || t_ovf !== ov) begin
            n_fail++; $display("FAIL rnd_t: got %0d/%b want %0d/%b", t_acc, t_ovf, e, ov);
         end
         n_tests++;
         if (!idle || lat != 3) begin
            n_fail++; $display("FAIL rnd_flow: got idle=%b lat=%0d want 1/3", idle, lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_saturation();
      test_stall_backpressure();
      test_len0_ignored_start();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_accumulator.md
PE_ACCUMULATOR -- requirements
Module: pe_accumulator

Interface
REQ-001 SHALL have parameter MUL_W, default 32, meaning width of incoming product.
REQ-002 SHALL have parameter ACC_W, default 40, meaning accumulator width, ACC_W >= MUL_W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the product-count field.
REQ-004 SHALL have parameter SIGNED, default 0, meaning 1 = two's-complement products.
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port i_en_ff, input, 1, pipeline enable (stall when 0).
REQ-008 SHALL have port i_start, input, 1, begin a new accumulation context.
REQ-009 SHALL have port i_acc_len, input, CNT_W, products per context, sampled with i_start.
REQ-010 SHALL have port i_prod, input, MUL_W, product from the multiplier.
REQ-011 SHALL have port i_prod_valid, input, 1, i_prod is valid.
REQ-012 SHALL have port o_prod_ready, output, 1, block accepts a product this cycle.
REQ-013 SHALL have port o_acc, output, ACC_W, accumulated result.
REQ-014 SHALL have port o_acc_valid, output, 1, o_acc holds a completed context.
REQ-015 SHALL have port i_acc_ready, input, 1, consumer accepts o_acc.
REQ-016 SHALL have port o_ovf, output, 1, sticky saturation flag for the presented context.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, FLUSH and DRAIN.
REQ-018 SHALL move IDLE->ACCUM on i_start with i_acc_len>0, clearing the accumulator, o_ovf and the count.
REQ-019 SHALL move IDLE->DRAIN on i_start with i_acc_len==0, presenting o_acc=0.
REQ-020 SHALL ignore i_start in every state other than IDLE.
REQ-021 SHALL drive o_prod_ready=1 only in ACCUM while accepted count < i_acc_len and i_en_ff=1.
REQ-022 SHALL accept a product when i_prod_valid & o_prod_ready, registering it in stage 1 (1 cycle).
REQ-023 SHALL add the stage-1 product to the accumulator one cycle later (accept-to-update latency 2).
REQ-024 SHALL sign-extend i_prod to ACC_W when SIGNED=1 and zero-extend it otherwise.
REQ-025 SHALL clamp to the ACC_W max/min (signed) or max (unsigned) on overflow and set o_ovf.
REQ-026 SHALL move ACCUM->FLUSH on the cycle the i_acc_len-th product is accepted.
REQ-027 SHALL move FLUSH->DRAIN once the final stage-1 add completes.
REQ-028 SHALL hold o_acc_valid=1 in DRAIN, with o_acc and o_ovf stable until the handshake completes.
REQ-029 SHALL move DRAIN->IDLE on o_acc_valid & i_acc_ready.
REQ-030 SHALL freeze stage 1, the accumulator, the counter and FSM transitions while i_en_ff=0, except the DRAIN handshake.
REQ-031 SHALL not accept a product while i_prod_valid=1 and i_en_ff=0 (o_prod_ready=0).

Reset
REQ-032 SHALL, on i_rst=1 at a clock edge, return to IDLE with o_acc=0, o_acc_valid=0, o_ovf=0, o_prod_ready=0, stage 1 invalid and count 0.
REQ-033 SHALL give reset priority over i_en_ff, aborting any partial context.

Structure
REQ-034 SHALL place the acc_state_t enum and the default MUL_W/ACC_W/CNT_W localparams in package sauria_pe_pkg.
REQ-035 SHALL implement the extend-and-saturate addition as sub-module sat_adder, parameterised by ACC_W and SIGNED.

Verification
REQ-036 SHALL test unsigned accumulation: len=4, products 1,2,3,4 back-to-back -> o_acc=10, o_acc_valid rises 3 cycles after the last accept, o_ovf=0.
REQ-037 SHALL test signed accumulation: SIGNED=1, len=3, products -5,+2,-1 -> o_acc=-4, o_ovf=0.
REQ-038 SHALL test saturation: ACC_W=MUL_W=8, unsigned, len=2, products 200,100 -> o_acc=255, o_ovf=1.
REQ-039 SHALL test stall and backpressure: i_en_ff=0 for 3 cycles mid-context, then i_acc_ready held low for 5 cycles -> no product lost or duplicated, o_acc stable, return to IDLE only after the handshake.
REQ-040 SHALL test len=0 and the ignored start: i_start with len=0 -> DRAIN with o_acc=0; i_start issued during ACCUM -> no effect.
REQ-041 SHALL test reset mid-context: i_rst after 2 of 4 products -> all outputs 0, IDLE next cycle, a fresh context with len=1 and product 7 -> o_acc=7.
